// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types for the UART transmit-side blocks.
//            arb_state_t is the sequencing state of uart_tx_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // IDLE  : waiting for a request (or re-granting a locked owner)
    // START : one-cycle launch of the frame and acknowledge to the requester
    // WAIT  : frame in flight, waiting for the transmitter's done tick
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : uart_rr_pick
// Purpose  : Combinational round-robin selector. Searches req starting one
//            position after ptr, wrapping modulo NREQ (NREQ need not be a
//            power of two), and reports the first asserted index.
// Ports    : req   in  NREQ  request vector
//            ptr   in  IW    most recent winner (search starts at ptr+1)
//            valid out 1     at least one request asserted
//            idx   out IW    winning index (0 when valid is low)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] w_cand;

    // Offset k=1..NREQ visits every requester exactly once, ptr itself last,
    // so a sole requester that just won can win again. The modulo keeps the
    // wrap correct when NREQ is not a power of two.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IW'((int'(ptr) + k) % NREQ);
            if (!valid && req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule : uart_rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmitter between NREQ byte-stream clients.
//            Round-robin arbitration, one byte per frame, ownership locked
//            across multi-byte packets until the byte flagged last is sent.
// Ports    : clk, reset_n (async, active low)
//            req / req_data / req_last   per-client pending byte
//            req_ack                     one-cycle accept pulse per client
//            tx_start / tx_din           frame launch and byte to send
//            tx_done_tick                end-of-frame pulse from transmitter
//            owner                       current or most recent grantee
//            busy                        sequencing or packet lock held
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DBIT = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DBIT-1:0]     req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ack,
    output logic                     tx_start,
    output logic [DBIT-1:0]          tx_din,
    input  logic                     tx_done_tick,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy
);

    localparam int c_IDX_W = $clog2(NREQ);

    arb_state_t          r_state;
    logic                r_lock;
    logic                r_last_q;
    logic [c_IDX_W-1:0]  r_owner;
    logic [DBIT-1:0]     r_tx_din;
    logic                r_tx_start;
    logic [NREQ-1:0]     r_req_ack;

    logic                w_pick_valid;
    logic [c_IDX_W-1:0]  w_pick_idx;
    logic                w_hold;
    logic                w_gnt_valid;
    logic [c_IDX_W-1:0]  w_gnt_idx;
    logic [DBIT-1:0]     w_gnt_data;
    logic                w_gnt_last;
    logic [NREQ-1:0]     w_gnt_onehot;

    uart_rr_pick #(
        .NREQ (NREQ),
        .IW   (c_IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (r_owner),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // A locked owner that still has a byte pending keeps the transmitter.
    // Otherwise the lock is dropped and normal round-robin applies in the
    // same IDLE cycle.
    assign w_hold      = r_lock & req[r_owner];
    assign w_gnt_valid = w_hold | w_pick_valid;
    assign w_gnt_idx   = w_hold ? r_owner : w_pick_idx;

    // Index-compare mux keeps every select in range for non-power-of-two NREQ.
    always_comb begin
        w_gnt_data   = '0;
        w_gnt_last   = 1'b0;
        w_gnt_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == c_IDX_W'(i)) begin
                w_gnt_data      = req_data[i*DBIT +: DBIT];
                w_gnt_last      = req_last[i];
                w_gnt_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_lock     <= 1'b0;
            r_last_q   <= 1'b0;
            r_owner    <= c_IDX_W'(NREQ - 1);   // requester 0 wins first
            r_tx_din   <= '0;
            r_tx_start <= 1'b0;
            r_req_ack  <= '0;
        end else begin
            r_tx_start <= 1'b0;
            r_req_ack  <= '0;
            case (r_state)
                IDLE: begin
                    r_lock <= w_hold;
                    if (w_gnt_valid) begin
                        r_tx_din   <= w_gnt_data;
                        r_last_q   <= w_gnt_last;
                        r_owner    <= w_gnt_idx;
                        // Raised here so they are high for exactly the START cycle.
                        r_tx_start <= 1'b1;
                        r_req_ack  <= w_gnt_onehot;
                        r_state    <= START;
                    end
                end
                START: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (tx_done_tick) begin
                        r_lock  <= ~r_last_q;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx_start = r_tx_start;
    assign req_ack  = r_req_ack;
    assign tx_din   = r_tx_din;
    assign owner    = r_owner;
    assign busy     = (r_state != IDLE) | r_lock;

endmodule : uart_tx_arbiter
`default_nettype wire
